// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, sample points, data widths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [3:0] SAMPLE_MID = 4'd7;
    localparam logic [3:0] SAMPLE_END = 4'd15;

    localparam int unsigned DATA_BITS_7 = 7;
    localparam int unsigned DATA_BITS_8 = 8;

    // Value of bit_cnt when the final data bit of the frame is being sampled.
    function automatic logic [2:0] last_bit_idx(input logic bit8);
        return bit8 ? 3'(DATA_BITS_8 - 1) : 3'(DATA_BITS_7 - 1);
    endfunction

endpackage

// File: rtl/echo_control_uart_rx_sync.sv
// N-flop synchroniser for the asynchronous rx line; resets to the idle-high level.
module echo_control_uart_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/echo_control_uart_rx_core.sv
// UART receive engine: 16x oversampled start detection, 7/8 data bits, optional parity,
// stop-bit check, and a held-byte register with full/overflow handshake to the host.
module echo_control_uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned RX_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_byte,
    output logic       receive_full,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    logic       rx_s;
    rx_state_e  state_q, state_d;
    logic [3:0] samp_cnt_q, samp_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_bit_q, par_bit_d;
    logic       byte_done;
    logic [7:0] rx_data;
    logic       perr_new;

    echo_control_uart_rx_sync #(
        .STAGES (RX_SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        byte_done  = 1'b0;
        if (baud_clock) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        samp_cnt_d = '0;
                    end
                end
                START: begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == SAMPLE_MID) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            samp_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == SAMPLE_END) begin
                        shreg_d   = {rx_s, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == last_bit_idx(bit8)) begin
                            state_d = parity_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == SAMPLE_END) begin
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    if (samp_cnt_q == SAMPLE_END) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // 7-bit frames land in shreg[7:1] after LSB-first shifting; right-justify them.
    assign rx_data  = bit8 ? shreg_q : {1'b0, shreg_q[7:1]};
    assign perr_new = parity_en & ((^rx_data ^ odd_n_even) ^ par_bit_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte      <= '0;
            receive_full <= 1'b0;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
            overflow     <= 1'b0;
        end else if (byte_done) begin
            // A read on the completion cycle frees the slot, so the new byte wins.
            if (!receive_full || read_rx_byte) begin
                rx_byte      <= rx_data;
                receive_full <= 1'b1;
                parity_err   <= perr_new;
                framing_err  <= ~rx_s;
                overflow     <= 1'b0;
            end else begin
                overflow <= 1'b1;
            end
        end else if (read_rx_byte && receive_full) begin
            receive_full <= 1'b0;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
            overflow     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_echo_control_uart_rx_core.sv
// Self-checking bench for echo_control_uart_rx_core: table vectors, corner sequences, random frames.
module tb_echo_control_uart_rx_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       baud_clock;
    logic       baud_en;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic [7:0] rx_byte;
    logic       receive_full;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference model of the host-visible holding register.
    logic [7:0] m_byte;
    logic       m_full, m_perr, m_ferr, m_ovf;

    typedef struct {
        logic       b8;
        logic       pen;
        logic       odd;
        logic [7:0] data;
        logic       pbad;
        logic       stopb;
        logic       rd_before;
        logic       rd_done;
    } vec_t;

    vec_t tbl[9];

    echo_control_uart_rx_core #(
        .RX_SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_clock   (baud_clock),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_byte      (rx_byte),
        .receive_full (receive_full),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Tick on every other clk: 16 ticks per bit = 32 clk per bit.
    assign baud_clock = baud_en & cyc[0];

    function automatic vec_t mk(input logic b8, input logic pen, input logic odd,
                                input logic [7:0] data, input logic pbad, input logic stopb,
                                input logic rd_before, input logic rd_done);
        vec_t v;
        v.b8 = b8; v.pen = pen; v.odd = odd; v.data = data;
        v.pbad = pbad; v.stopb = stopb; v.rd_before = rd_before; v.rd_done = rd_done;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check1({tag, ".rx_byte"},      rx_byte,      m_byte);
        check1({tag, ".receive_full"}, {7'd0, receive_full}, {7'd0, m_full});
        check1({tag, ".parity_err"},   {7'd0, parity_err},   {7'd0, m_perr});
        check1({tag, ".framing_err"},  {7'd0, framing_err},  {7'd0, m_ferr});
        check1({tag, ".overflow"},     {7'd0, overflow},     {7'd0, m_ovf});
    endtask

    task automatic model_reset();
        m_byte = '0; m_full = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic read_pulse();
        read_rx_byte = 1'b1;
        step();
        read_rx_byte = 1'b0;
        if (m_full) begin
            m_full = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        end
    endtask

    task automatic align_to_tick();
        while (cyc[0] == 1'b0) step();
    endtask

    // Sends one frame. The stop bit is sampled mid-bit, 50 + 32*(data+parity bits) clk after
    // the start edge given 2 sync flops and a tick on the first edge. abort_edge>0 resets there.
    task automatic send_frame(input vec_t v, input int abort_edge);
        logic [11:0] frame;
        logic [7:0]  exp_byte;
        logic        pbit;
        int          nb, len, done_edge, n;
        bit8 = v.b8; parity_en = v.pen; odd_n_even = v.odd;
        nb = v.b8 ? 8 : 7;
        exp_byte = v.b8 ? v.data : {1'b0, v.data[6:0]};
        pbit = (^exp_byte) ^ v.odd ^ v.pbad;
        frame = '0;
        for (int i = 0; i < nb; i++) frame[1+i] = exp_byte[i];
        if (v.pen) frame[1+nb] = pbit;
        len = nb + (v.pen ? 1 : 0) + 2;
        frame[len-1] = v.stopb;
        done_edge = 50 + 32 * (len - 2);
        align_to_tick();
        n = 0;
        for (int b = 0; b < len; b++) begin
            rx = frame[b];
            for (int k = 0; k < 32; k++) begin
                if (v.rd_done && n == done_edge) read_rx_byte = 1'b1;
                step();
                read_rx_byte = 1'b0;
                n++;
                if (abort_edge > 0 && n == abort_edge) begin
                    reset_n = 1'b0;
                    model_reset();
                    return;
                end
            end
        end
        rx = 1'b1;
        if (!m_full || v.rd_done) begin
            m_byte = exp_byte;
            m_full = 1'b1;
            m_perr = v.pen & v.pbad;
            m_ferr = ~v.stopb;
            m_ovf  = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
        repeat (40) step();
    endtask

    initial begin
        vec_t rv;
        reset_n = 1'b0; rx = 1'b1; baud_en = 1'b1;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; read_rx_byte = 1'b0;
        model_reset();

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[3] = mk(1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[4] = mk(1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[5] = mk(1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[6] = mk(1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[7] = mk(1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[8] = mk(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) step();
        check_all("reset");
        reset_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rd_before) begin
                read_pulse();
                check_all($sformatf("vec%0d.read", i));
            end
            send_frame(tbl[i], 0);
            check_all($sformatf("vec%0d", i));
        end

        // Break: line held low keeps completing frames with bad stop bits into a full slot.
        rx = 1'b0;
        repeat (960) step();
        m_ovf = 1'b1;
        check_all("break");
        rx = 1'b1;
        repeat (400) step();
        read_pulse();
        check_all("break.read");
        send_frame(mk(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0), 0);
        check_all("after_break");

        // Short low glitch from idle must be rejected by start validation.
        read_pulse();
        align_to_tick();
        rx = 1'b0;
        repeat (8) step();
        rx = 1'b1;
        repeat (60) step();
        check_all("glitch");

        // Reset during data bit 3 while a byte is held.
        send_frame(mk(1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0), 0);
        check_all("pre_reset");
        send_frame(mk(1'b1, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0), 144);
        #1;
        check_all("mid_reset");
        rx = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        send_frame(mk(1'b1, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0), 0);
        check_all("post_reset");

        for (int i = 0; i < 30; i++) begin
            rv = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            if (rv.rd_before) read_pulse();
            send_frame(rv, 0);
            check_all($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
